// File: rtl/button_if.sv
// Button conditioner bus: raw pad levels in, debounced level and press/release events out.
// The released signal exists only when BTN_RELEASE_EVT_EN is defined.
interface button_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] out;
`ifdef BTN_RELEASE_EVT_EN
  logic [WIDTH-1:0] released;

  modport master (output in, input level, input out, input released);
  modport slave  (input in, output level, output out, output released);
`else
  modport master (output in, input level, input out);
  modport slave  (input in, output level, output out);
`endif
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects push-buttons on one shared sample tick.
// Optional release pulses are enabled by defining BTN_RELEASE_EVT_EN.
module button_conditioner #(
  parameter int WIDTH            = 4,
  parameter int SAMPLE_COUNT_MAX = 25000,
  parameter int PULSE_COUNT_MAX  = 200,
  parameter int SYNC_STAGES      = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  button_if.slave  bus
);

  localparam int SC_W  = $clog2(SAMPLE_COUNT_MAX) + 1;
  localparam int CNT_W = $clog2(PULSE_COUNT_MAX) + 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SAMPLE_COUNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_COUNT_MAX);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [SC_W-1:0]  r_sc;
  logic [WIDTH-1:0] r_level_d;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_level;
  logic             w_tick;

  // NOTE: the sync array is reset too, so no stale pad level can qualify after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_sc == SC_LAST);

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sc <= '0;
    else if (w_tick) r_sc <= '0;
    else             r_sc <= r_sc + SC_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;

    // Any low sample restarts the count; a full count saturates while held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        if (!w_s[i])                r_cnt <= '0;
        else if (r_cnt < CNT_FULL)  r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_level[i] = (r_cnt == CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_level_d <= '0;
    else        r_level_d <= w_level;
  end

  assign bus.level = w_level;
  assign bus.out   = w_level & ~r_level_d;
`ifdef BTN_RELEASE_EVT_EN
  assign bus.released = ~w_level & r_level_d;
`endif

endmodule
